lfsr_rng_gen: RTL and testbench
===============================

LFSR_RNG_GEN -- requirements
Module: lfsr_rng_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- S_WIDTH, 8, state and output width (legal range 8..32).
- TAPS, 8'hB8, Galois feedback mask (S_WIDTH bits); the default is x^8+x^6+x^5+x^4+1.
- R_MAX, 40, upper bound of range mode (legal range 1..255).
REQ-002 Ports (name, direction, width, meaning), one per line; the block SHALL use one clock, and reset SHALL be asynchronous and active-low:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- seed_valid_i, in, 1, load seed this cycle.
- random_seed_i, in, S_WIDTH, seed value.
- clear_i, in, 1, synchronous return to IDLE.
- en_i, in, 1, step request.
- mode_i, in, 2, output mapping: 0 raw, 1 range 0..3, 2 range 1..R_MAX, 3 raw.
- out_ready_i, in, 1, consumer accepts rand_o.
- out_valid_o, out, 1, rand_o holds a new sample.
- rand_o, out, S_WIDTH, mapped random number.
- period_o, out, 1, one-cycle pulse when the state returns to the loaded seed.

Function
REQ-003 FSM SHALL have two states, IDLE and RUN; it leaves reset in IDLE.
REQ-004 IDLE->RUN on seed_valid_i=1; RUN->IDLE on clear_i=1; all other cases hold the current state.
REQ-005 clear_i SHALL have priority over seed_valid_i in the same cycle: the result is IDLE, the state register is unchanged, and out_valid_o is 0 next cycle.
REQ-006 Seed load: state <= random_seed_i, and seed_reg <= random_seed_i. If random_seed_i==0, both SHALL load 1 instead (lock-up avoidance).
REQ-007 Seed load in RUN SHALL restart the sequence: same actions as REQ-006, and out_valid_o=0 next cycle.
REQ-008 step = (state==RUN) && en_i && !seed_valid_i && !clear_i && (!out_valid_o || out_ready_i).
REQ-009 On step, the next state SHALL be (state >> 1) XOR (state[0] ? TAPS : 0), computed over S_WIDTH bits.
REQ-010 On step, rand_o and out_valid_o=1 SHALL be registered from the next state. Latency: the step cycle produces a valid output on the following edge.
REQ-011 Handshake: when out_valid_o=1 and out_ready_i=0, rand_o, out_valid_o and the state SHALL hold unchanged regardless of en_i.
REQ-012 If out_valid_o=1, out_ready_i=1 and no step occurs, out_valid_o SHALL go to 0 next cycle.
REQ-013 Mapping mode 0 and mode 3: rand_o = next state.
REQ-014 Mapping mode 1: rand_o = zero-extended next_state[1:0].
REQ-015 Mapping mode 2: rand_o = zero-extended (((next_state[7:0] * R_MAX) >> 8) + 1). The product SHALL be 16 bits; the result range is 1..R_MAX.
REQ-016 mode_i SHALL be sampled on the step cycle only; a mode change never alters a held output.
REQ-017 period_o SHALL pulse for one cycle, coincident with out_valid_o rising with the new sample, when the step's next state equals seed_reg.
REQ-018 If the state is ever 0 in RUN (non-primitive TAPS only), the next step SHALL load seed_reg instead of shifting.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: FSM=IDLE, state=0, seed_reg=0, rand_o=0, out_valid_o=0, period_o=0.
REQ-020 Reset asserted mid-RUN SHALL discard any pending output. After release, the block SHALL stay in IDLE with out_valid_o=0 until the next seed_valid_i.

Verification
REQ-021 Defaults, seed 0x01, mode 0, en_i=1, ready=1 -> rand_o sequence 0xB8, 0x5C, 0x2E, 0x17, 0xB3, with out_valid_o=1 from the edge after the first step.
REQ-022 Seed 0x01 with continuous stepping -> period_o pulses on sample 255 (rand_o=0x01) and every 255 samples thereafter; no sample equals 0x00.
REQ-023 Seed 0x01, mode 2 -> first samples 29, 15; mode 1 -> first samples 0, 0, 2, 3; all values within range.
REQ-024 Seed 0x00 -> behaviour identical to seed 0x01 (first sample 0xB8).
REQ-025 Backpressure: ready=0 for 5 cycles with out_valid_o=1 -> rand_o holds 0xB8; after ready=1, the next sample is 0x5C.
REQ-026 clear_i and seed_valid_i asserted together in RUN -> IDLE, out_valid_o=0, no further samples. Separately, rst_n pulsed mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_rng_gen.sv
// Galois LFSR random number generator with seed load, range mapping,
// ready/valid output handshake and a period-detect pulse.
module lfsr_rng_gen #(
   parameter int unsigned        S_WIDTH = 8,
   parameter logic [S_WIDTH-1:0] TAPS    = 8'hB8,
   parameter int unsigned        R_MAX   = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_valid_i,
   input  logic [S_WIDTH-1:0] random_seed_i,
   input  logic               clear_i,
   input  logic               en_i,
   input  logic [1:0]         mode_i,
   input  logic               out_ready_i,
   output logic               out_valid_o,
   output logic [S_WIDTH-1:0] rand_o,
   output logic               period_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   // Scaled range uses only the low byte; the 16-bit product keeps the result in 1..R_MAX.
   function automatic logic [S_WIDTH-1:0] map_sample(input logic [1:0]         mode,
                                                     input logic [S_WIDTH-1:0] ns);
      logic [15:0] prod;
      logic [7:0]  scaled;
      prod   = {8'd0, ns[7:0]} * 16'(R_MAX);
      scaled = prod[15:8] + 8'd1;
      case (mode)
         2'd1:    map_sample = S_WIDTH'(ns[1:0]);
         2'd2:    map_sample = S_WIDTH'(scaled);
         default: map_sample = ns;
      endcase
   endfunction

   fsm_t               fsm_q, fsm_d;
   logic [S_WIDTH-1:0] state_q, state_d;
   logic [S_WIDTH-1:0] seed_q, seed_d;
   logic [S_WIDTH-1:0] rand_q, rand_d;
   logic               valid_q, valid_d;
   logic               period_q, period_d;

   logic               step_s;
   logic [S_WIDTH-1:0] seed_eff_s;
   logic [S_WIDTH-1:0] lfsr_next_s;

   // Step qualification, seed sanitising and the LFSR advance.
   always_comb begin
      step_s = (fsm_q == RUN) && en_i && !seed_valid_i && !clear_i
               && (!valid_q || out_ready_i);
      if (random_seed_i == {S_WIDTH{1'b0}}) begin
         seed_eff_s = S_WIDTH'(1'b1);
      end else begin
         seed_eff_s = random_seed_i;
      end
      // An all-zero state can only arise with a non-primitive mask; recover from the seed.
      if (state_q == {S_WIDTH{1'b0}}) begin
         lfsr_next_s = seed_q;
      end else if (state_q[0]) begin
         lfsr_next_s = (state_q >> 1) ^ TAPS;
      end else begin
         lfsr_next_s = state_q >> 1;
      end
   end

   // Next-state selection: clear beats seed load, seed load beats stepping.
   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      seed_d   = seed_q;
      rand_d   = rand_q;
      valid_d  = valid_q;
      period_d = 1'b0;
      if (clear_i) begin
         fsm_d   = IDLE;
         valid_d = 1'b0;
      end else if (seed_valid_i) begin
         fsm_d   = RUN;
         state_d = seed_eff_s;
         seed_d  = seed_eff_s;
         valid_d = 1'b0;
      end else if (step_s) begin
         state_d  = lfsr_next_s;
         rand_d   = map_sample(mode_i, lfsr_next_s);
         valid_d  = 1'b1;
         period_d = (lfsr_next_s == seed_q);
      end else if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         state_q  <= {S_WIDTH{1'b0}};
         seed_q   <= {S_WIDTH{1'b0}};
         rand_q   <= {S_WIDTH{1'b0}};
         valid_q  <= 1'b0;
         period_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         seed_q   <= seed_d;
         rand_q   <= rand_d;
         valid_q  <= valid_d;
         period_q <= period_d;
      end
   end

   assign out_valid_o = valid_q;
   assign rand_o      = rand_q;
   assign period_o    = period_q;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Self-checking bench for lfsr_rng_gen: directed vectors plus a randomized
// phase, all compared against a cycle-level reference model.
module tb_lfsr_rng_gen;

   localparam int W  = 8;
   localparam int TP = 184;
   localparam int RM = 40;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         seed_valid_i = 1'b0;
   logic [W-1:0] random_seed_i = 8'd0;
   logic         clear_i = 1'b0;
   logic         en_i = 1'b0;
   logic [1:0]   mode_i = 2'd0;
   logic         out_ready_i = 1'b0;
   logic         out_valid_o;
   logic [W-1:0] rand_o;
   logic         period_o;

   int checks = 0;
   int failures = 0;

   bit m_run = 1'b0, m_valid = 1'b0, m_period = 1'b0;
   int m_state = 0, m_seed = 0, m_rand = 0;

   always #5 clk = ~clk;

   lfsr_rng_gen #(.S_WIDTH(W), .TAPS(8'hB8), .R_MAX(RM)) dut (
      .clk(clk), .rst_n(rst_n), .seed_valid_i(seed_valid_i),
      .random_seed_i(random_seed_i), .clear_i(clear_i), .en_i(en_i),
      .mode_i(mode_i), .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
      .rand_o(rand_o), .period_o(period_o)
   );

   // Division by x in GF(2)[x] modulo the feedback polynomial.
   function automatic int adv(input int s, input int sd);
      if (s == 0) return sd;
      if (s % 2 == 1) return (s / 2) ^ TP;
      return s / 2;
   endfunction

   function automatic int mapv(input int mode, input int s);
      case (mode)
         1: return s % 4;
         2: return ((s % 256) * RM) / 256 + 1;
         default: return s;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit stp;
      int ns;
      stp = m_run && en_i && !seed_valid_i && !clear_i && (!m_valid || out_ready_i);
      m_period = 1'b0;
      if (clear_i) begin
         m_run = 1'b0; m_valid = 1'b0;
      end else if (seed_valid_i) begin
         m_run = 1'b1;
         m_state = (random_seed_i == 8'd0) ? 1 : int'(random_seed_i);
         m_seed = m_state;
         m_valid = 1'b0;
      end else if (stp) begin
         ns = adv(m_state, m_seed);
         m_state = ns;
         m_rand = mapv(int'(mode_i), ns);
         m_valid = 1'b1;
         m_period = (ns == m_seed);
      end else if (m_valid && out_ready_i) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_valid = 1'b0; m_period = 1'b0;
      m_state = 0; m_seed = 0; m_rand = 0;
   endtask

   task automatic drive(input bit sv, input int sd, input bit clr, input bit en,
                        input int md, input bit rdy);
      seed_valid_i = sv; random_seed_i = W'(sd); clear_i = clr;
      en_i = en; mode_i = 2'(md); out_ready_i = rdy;
   endtask

   task automatic cyc();
      model_update();
      @(posedge clk);
      #1;
      chk("valid", {31'd0, out_valid_o}, {31'd0, m_valid});
      chk("rand", {24'd0, rand_o}, 32'(m_rand));
      chk("period", {31'd0, period_o}, {31'd0, m_period});
   endtask

   initial begin
      int exp21[5];
      int n, pulses, zeros;
      exp21 = '{184, 92, 46, 23, 179};

      @(posedge clk);
      #1;
      chk("reset_valid", {31'd0, out_valid_o}, 32'd0);
      chk("reset_rand", {24'd0, rand_o}, 32'd0);
      chk("reset_period", {31'd0, period_o}, 32'd0);
      rst_n = 1'b1;

      // Stepping while IDLE produces nothing.
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      repeat (3) cyc();

      // Basic sequence from seed 0x01.
      drive(1'b1, 1, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      chk("seed_load_valid", {31'd0, out_valid_o}, 32'd0);
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("seq_basic", {24'd0, rand_o}, 32'(exp21[i]));
         chk("seq_basic_valid", {31'd0, out_valid_o}, 32'd1);
      end

      // Period detection across two full cycles.
      drive(1'b1, 1, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      n = 0; pulses = 0; zeros = 0;
      for (int i = 0; i < 510; i++) begin
         cyc();
         n++;
         if (rand_o == 8'd0) zeros++;
         if (period_o) pulses++;
         if (n == 255) begin
            chk("period_at_255", {31'd0, period_o}, 32'd1);
            chk("rand_at_255", {24'd0, rand_o}, 32'd1);
         end
      end
      chk("period_pulses", 32'(pulses), 32'd2);
      chk("zero_samples", 32'(zeros), 32'd0);

      // Range modes.
      drive(1'b1, 1, 1'b0, 1'b1, 2, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 2, 1'b1);
      cyc(); chk("mode2_s0", {24'd0, rand_o}, 32'd29);
      cyc(); chk("mode2_s1", {24'd0, rand_o}, 32'd15);
      drive(1'b1, 1, 1'b0, 1'b1, 1, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 1, 1'b1);
      cyc(); chk("mode1_s0", {24'd0, rand_o}, 32'd0);
      cyc(); chk("mode1_s1", {24'd0, rand_o}, 32'd0);
      cyc(); chk("mode1_s2", {24'd0, rand_o}, 32'd2);
      cyc(); chk("mode1_s3", {24'd0, rand_o}, 32'd3);

      // Zero seed behaves as seed 0x01.
      drive(1'b1, 0, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      cyc(); chk("seed_zero", {24'd0, rand_o}, 32'd184);

      // Backpressure hold with mode toggling.
      drive(1'b1, 1, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 0, 1'b0, 1'b1, (i % 3) + 1, 1'b0);
         cyc();
         chk("bp_hold", {24'd0, rand_o}, 32'd184);
         chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      end
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      cyc(); chk("bp_release", {24'd0, rand_o}, 32'd92);

      // Clear wins over seed load.
      drive(1'b1, 51, 1'b1, 1'b1, 0, 1'b1);
      cyc();
      chk("clear_prio_valid", {31'd0, out_valid_o}, 32'd0);
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("clear_idle_valid", {31'd0, out_valid_o}, 32'd0);
      end

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 15) == 0,
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
               $urandom_range(0, 40) == 0,
               $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 3)),
               $urandom_range(0, 2) != 0);
         cyc();
      end

      // Asynchronous reset mid-stream.
      drive(1'b1, 7, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      repeat (3) cyc();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("async_rst_rand", {24'd0, rand_o}, 32'd0);
      chk("async_rst_period", {31'd0, period_o}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("post_rst_idle", {31'd0, out_valid_o}, 32'd0);
      end
      drive(1'b1, 1, 1'b0, 1'b1, 0, 1'b1);
      cyc();
      drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b1);
      cyc(); chk("post_rst_first", {24'd0, rand_o}, 32'd184);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
